uart_tx_fifo_feeder: RTL and testbench

//  Byte buffer and send sequencer sitting directly upstream of the UART transmitter.

---
 rtl/uart_tx_fifo_feeder.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus send sequencer in front of the UART transmitter.
// Bytes pushed by the producer are queued in a circular buffer and handed to the
// transmitter one at a time over the tx_send/tx_data/tx_sent handshake.
// tx_data stays stable for the whole frame.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en, wr_data   push request and byte; ignored (overflow pulse) when full
//   full, empty      registered FIFO status
//   count            bytes stored, excluding the byte in flight
//   overflow         one-cycle pulse after a push was attempted while full
//   busy             high whenever the sequencer is not idle
//   tx_send          one-cycle start strobe to the transmitter
//   tx_data          byte in flight
//   tx_sent          end-of-frame pulse from the transmitter
module uart_tx_fifo_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_sent
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    count_next;
    logic                wr_accept;
    logic                pop;
    logic                busy_next;
    logic                tx_send_next;

    // A pop in the same cycle never frees space for the incoming byte.
    assign wr_accept = wr_en & ~full;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, pop decision and next values of the Moore outputs.
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                if (tx_sent) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next    = (state_next != IDLE);
        tx_send_next = (state_next == SEND);
    end

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        case ({wr_accept, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, status flags and transmitter-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            busy     <= 1'b0;
            tx_send  <= 1'b0;
            tx_data  <= '0;
        end else begin
            count    <= count_next;
            full     <= (count_next == CNT_W'(DEPTH));
            empty    <= (count_next == '0);
            overflow <= wr_en & full;
            busy     <= busy_next;
            tx_send  <= tx_send_next;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                tx_data <= mem[rd_ptr];
            end
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: directed steps plus a randomized
// push/pop run checked against a queue-based model of the expected byte stream.
module tb_uart_tx_fifo_feeder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic              tx_send;
    logic [7:0]        tx_data;
    logic              tx_sent;

    // Transmitter model: replies tx_sent tx_delay cycles after each strobe when enabled.
    logic              man_sent  = 1'b0;
    logic              auto_sent = 1'b0;
    logic              tx_auto   = 1'b0;
    int                tx_delay  = 5;
    int                tx_timer  = 0;

    int                cyc       = 0;
    byte unsigned      rx_q[$];
    int                rx_cyc[$];
    int                max_count = 0;

    int                n_chk  = 0;
    int                n_fail = 0;

    assign tx_sent = man_sent | auto_sent;

    uart_tx_fifo_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_sent  (tx_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every strobe with its byte and cycle, and the peak occupancy.
    always @(negedge clk) begin
        if (tx_send === 1'b1) begin
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
        if (rst === 1'b0 && int'(count) > max_count) begin
            max_count = int'(count);
        end
    end

    always @(negedge clk) begin
        auto_sent = 1'b0;
        if (tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) begin
                auto_sent = 1'b1;
            end
        end
        if (tx_send === 1'b1 && tx_auto) begin
            tx_timer = tx_delay;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(busy === 1'b0 && empty === 1'b1), 32'd1);
    endtask

    initial begin
        int           t0;
        int           base;
        int           written;
        int           guard;
        byte unsigned b;
        byte unsigned exp_q[$];

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_tx_send",  32'(tx_send),  32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Single byte: strobe two cycles after the push, data held until tx_sent
        tx_auto  = 1'b1;
        tx_delay = 5;
        base     = rx_q.size();
        t0       = cyc;
        wr_en    = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("t1_c1_empty",   32'(empty),   32'd0);
        chk("t1_c1_count",   32'(count),   32'd1);
        chk("t1_c1_tx_send", 32'(tx_send), 32'd0);
        chk("t1_c1_busy",    32'(busy),    32'd0);
        tick();
        chk("t1_c2_tx_send", 32'(tx_send), 32'd1);
        chk("t1_c2_tx_data", 32'(tx_data), 32'hA5);
        chk("t1_c2_busy",    32'(busy),    32'd1);
        chk("t1_c2_count",   32'(count),   32'd0);
        tick();
        chk("t1_c3_tx_send", 32'(tx_send), 32'd0);
        chk("t1_c3_tx_data", 32'(tx_data), 32'hA5);
        repeat (4) tick();
        chk("t1_c7_busy",    32'(busy),    32'd1);
        chk("t1_c7_tx_data", 32'(tx_data), 32'hA5);
        tick();
        chk("t1_c8_busy",    32'(busy),    32'd0);
        chk("t1_c8_tx_data", 32'(tx_data), 32'hA5);
        chk("t1_c8_count",   32'(count),   32'd0);
        chk("t1_strobe_cyc", 32'(rx_cyc[base] - t0), 32'd2);
        chk("t1_strobes",    32'(rx_q.size() - base), 32'd1);

        // Five back-to-back pushes, transmitter answers 20 cycles after each strobe
        tx_delay = 20;
        base     = rx_q.size();
        t0       = cyc;
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        wait_rx(base + 5, 400, "t2_strobes_timeout");
        wait_idle(100, "t2_idle_timeout");
        chk("t2_first_latency", 32'(rx_cyc[base] - t0), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("t2_order", 32'(rx_q[base + i]), 32'(i + 1));
            if (i > 0) begin
                chk("t2_gap", 32'(rx_cyc[base + i] - rx_cyc[base + i - 1]), 32'd22);
            end
        end

        // Stalled transmitter: 17 pushes fill the FIFO behind the byte in flight
        tx_auto = 1'b0;
        base    = rx_q.size();
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_data = 8'h41;
        chk("t3_count_full",   32'(count),    32'd16);
        chk("t3_full",         32'(full),     32'd1);
        chk("t3_no_overflow",  32'(overflow), 32'd0);
        chk("t3_busy",         32'(busy),     32'd1);
        chk("t3_inflight",     32'(tx_data),  32'h30);
        tick();
        wr_en = 1'b0;
        chk("t3_overflow",     32'(overflow), 32'd1);
        chk("t3_count_kept",   32'(count),    32'd16);
        tick();
        chk("t3_overflow_end", 32'(overflow), 32'd0);
        chk("t3_count_still",  32'(count),    32'd16);
        chk("t3_one_strobe",   32'(rx_q.size() - base), 32'd1);

        // Full FIFO: push in the same cycle as an idle pop is still rejected
        man_sent = 1'b1;
        tick();
        man_sent = 1'b0;
        chk("t4_idle",       32'(busy),  32'd0);
        chk("t4_still_full", 32'(full),  32'd1);
        tx_auto  = 1'b1;
        tx_delay = 3;
        wr_en    = 1'b1;
        wr_data  = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("t4_count",    32'(count),    32'd15);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_not_full", 32'(full),     32'd0);
        chk("t4_tx_send",  32'(tx_send),  32'd1);
        chk("t4_tx_data",  32'(tx_data),  32'h31);
        wait_rx(base + 17, 2000, "t4_drain_timeout");
        wait_idle(200, "t4_idle_timeout");
        chk("t4_total_sent", 32'(rx_q.size() - base), 32'd17);
        for (int i = 0; i < 17; i++) begin
            chk("t4_order", 32'(rx_q[base + i]), 32'(8'h30 + i));
        end

        // Randomized traffic across pointer wrap, checked against the pushed sequence
        base    = rx_q.size();
        written = 0;
        guard   = 0;
        while (written < 40 && guard < 4000) begin
            if ($urandom_range(0, 3) != 0 && (written - (rx_q.size() - base)) < 16) begin
                b       = 8'($urandom);
                wr_en   = 1'b1;
                wr_data = b;
                exp_q.push_back(b);
                written++;
            end else begin
                wr_en = 1'b0;
            end
            tx_delay = int'($urandom_range(1, 8));
            tick();
            guard++;
        end
        wr_en = 1'b0;
        chk("t5_written", 32'(written), 32'd40);
        wait_rx(base + 40, 3000, "t5_drain_timeout");
        wait_idle(200, "t5_idle_timeout");
        chk("t5_total_sent", 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("t5_order", 32'(rx_q[base + i]), 32'(exp_q[i]));
        end
        chk("t5_max_count", 32'(max_count <= 16), 32'd1);

        // Reset while waiting on the transmitter with three bytes queued
        tx_delay = 30;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        repeat (2) tick();
        chk("t6_busy_pre",  32'(busy),    32'd1);
        chk("t6_count_pre", 32'(count),   32'd3);
        chk("t6_data_pre",  32'(tx_data), 32'hC0);
        rst  = 1'b1;
        base = rx_q.size();
        tick();
        rst = 1'b0;
        chk("t6_busy",     32'(busy),     32'd0);
        chk("t6_count",    32'(count),    32'd0);
        chk("t6_empty",    32'(empty),    32'd1);
        chk("t6_full",     32'(full),     32'd0);
        chk("t6_tx_send",  32'(tx_send),  32'd0);
        chk("t6_tx_data",  32'(tx_data),  32'h00);
        chk("t6_overflow", 32'(overflow), 32'd0);
        // The stale tx_sent from the abandoned frame lands inside this window
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("t6_stay_idle", 32'(busy), 32'd0);
        end
        chk("t6_no_strobe",  32'(rx_q.size() - base), 32'd0);
        chk("t6_count_post", 32'(count), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        tick();
        chk("t6_recover_send", 32'(tx_send), 32'd1);
        chk("t6_recover_data", 32'(tx_data), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
